// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the single-cycle MIPS-I subset core.
//   - opcode / funct encodings
//   - ALU operation and writeback-source enums
//   - default TEXT_BASE / DATA_BASE addresses
// Optional feature macro used by the core: MIPS_VAR_SHIFT_EN (sllv/srlv/srav).
package mips_pkg;

   localparam logic [31:0] TEXT_BASE_DEF = 32'h0000_3000;
   localparam logic [31:0] DATA_BASE_DEF = 32'h0000_0000;

   // Primary opcodes
   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type funct codes
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_ALU, WB_MEM, WB_LINK
   } wb_sel_e;

endpackage

// File: rtl/mips_dmem.sv
// mips_dmem: word-wide data memory, combinational read, posedge write.
// Ports:
//   clk  in   clock
//   rst  in   active-low reset; contents are kept, but a write is blocked while low
//   we   in   write enable
//   idx  in   word index (already truncated to the memory depth)
//   wd   in   write data
//   rd   out  read data at idx
module mips_dmem #(
   parameter int DM_DEPTH = 1024,
   localparam int DM_AW   = $clog2(DM_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [DM_AW-1:0] idx,
   input  logic [31:0]      wd,
   output logic [31:0]      rd
);
   logic [31:0] dataMem [0:DM_DEPTH-1];

   // A store retiring in the same cycle reset is asserted must not land.
   always_ff @(posedge clk) begin
      if (we && rst) dataMem[idx] <= wd;
   end

   assign rd = dataMem[idx];

endmodule

// File: rtl/mips_imem.sv
// mips_imem: read-only instruction store, contents preloaded from outside.
// Ports:
//   idx  in   word index (already truncated to the memory depth)
//   rd   out  instruction word at idx (combinational)
module mips_imem #(
   parameter int IM_DEPTH = 1024,
   localparam int IM_AW   = $clog2(IM_DEPTH)
) (
   input  logic [IM_AW-1:0] idx,
   output logic [31:0]      rd
);
   logic [31:0] instruction_memory [0:IM_DEPTH-1];

   assign rd = instruction_memory[idx];

endmodule

// File: rtl/mips_regfile.sv
// mips_regfile: 32 x 32-bit general purpose register file.
// Ports:
//   clk      in   clock, write on posedge
//   rst      in   asynchronous active-low reset, clears every register
//   ra1/ra2  in   read addresses (combinational reads)
//   rd1/rd2  out  read data; register 0 always reads zero
//   we/wa/wd in   write enable, address, data; writes to register 0 are dropped
module mips_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);
   import mips_pkg::*;

   logic [31:0] rf [0:31];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (we && (wa != 5'd0)) begin
         rf[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? 32'd0 : rf[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'd0 : rf[ra2];

endmodule

// File: rtl/mips_core.sv
// mips_core: single-cycle MIPS-I subset CPU. One instruction retires per clk;
// PC, register and data-memory writes commit together on posedge.
// Ports:
//   clk  in  single clock
//   rst  in  asynchronous active-low reset (PC=TEXT_BASE, GPRs cleared)
// Config macro: MIPS_VAR_SHIFT_EN enables sllv/srlv/srav; otherwise they are NOPs.
module mips_core #(
   parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
   parameter logic [31:0] DATA_BASE = 32'h0000_0000,
   parameter int          IM_DEPTH  = 1024,
   parameter int          DM_DEPTH  = 1024
) (
   input  logic clk,
   input  logic rst
);
   import mips_pkg::*;

   localparam int IM_AW = $clog2(IM_DEPTH);
   localparam int DM_AW = $clog2(DM_DEPTH);

   logic [31:0] PC, pc_next, pc_plus4, AnInstruction;
   logic [4:0]  shamt;
   logic [31:0] shamt32;
   logic [5:0]  op, funct;
   logic [4:0]  rs_a, rt_a, rd_a, wa;
   logic [15:0] imm16;
   logic [25:0] idx26;
   logic [31:0] imm_sext, imm_zext, br_target, j_target;
   logic [31:0] rs_val, rt_val, alu_a, alu_b, alu_y, wd, dm_rd;
   logic [31:0] im_off, dm_off;
   logic        reg_we, dm_we;
   alu_op_e     alu_op;
   wb_sel_e     wb_sel;
   logic        unused_bits;

   function automatic logic [31:0] alu_calc(input alu_op_e f, input logic [31:0] a,
                                            input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      case (f)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_NOR:  return ~(a | b);
         ALU_SLT:  return {31'd0, (sa < sb)};
         ALU_SLTU: return {31'd0, (a < b)};
         ALU_SLL:  return a << b[4:0];
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return sa >>> b[4:0];
         default:  return 32'd0;
      endcase
   endfunction

   // Fetch
   assign im_off = PC - TEXT_BASE;

   mips_imem #(.IM_DEPTH(IM_DEPTH)) im (
      .idx (im_off[IM_AW+1:2]),
      .rd  (AnInstruction)
   );

   assign op       = AnInstruction[31:26];
   assign rs_a     = AnInstruction[25:21];
   assign rt_a     = AnInstruction[20:16];
   assign rd_a     = AnInstruction[15:11];
   assign shamt    = AnInstruction[10:6];
   assign funct    = AnInstruction[5:0];
   assign imm16    = AnInstruction[15:0];
   assign idx26    = AnInstruction[25:0];
   assign shamt32  = {27'd0, shamt};
   assign imm_sext = {{16{imm16[15]}}, imm16};
   assign imm_zext = {16'd0, imm16};
   assign pc_plus4 = PC + 32'd4;
   assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
   assign j_target  = {pc_plus4[31:28], idx26, 2'b00};

   mips_regfile rf (
      .clk (clk),
      .rst (rst),
      .ra1 (rs_a),
      .ra2 (rt_a),
      .rd1 (rs_val),
      .rd2 (rt_val),
      .we  (reg_we),
      .wa  (wa),
      .wd  (wd)
   );

   // Decode: anything not listed falls through as a NOP (PC+4, no writes).
   always_comb begin
      alu_op  = ALU_ADD;
      alu_a   = rs_val;
      alu_b   = rt_val;
      reg_we  = 1'b0;
      wa      = rd_a;
      wb_sel  = WB_ALU;
      dm_we   = 1'b0;
      pc_next = pc_plus4;
      case (op)
         OP_R: begin
            case (funct)
               FN_ADDU: begin alu_op = ALU_ADD;  reg_we = 1'b1; end
               FN_SUBU: begin alu_op = ALU_SUB;  reg_we = 1'b1; end
               FN_AND:  begin alu_op = ALU_AND;  reg_we = 1'b1; end
               FN_OR:   begin alu_op = ALU_OR;   reg_we = 1'b1; end
               FN_XOR:  begin alu_op = ALU_XOR;  reg_we = 1'b1; end
               FN_NOR:  begin alu_op = ALU_NOR;  reg_we = 1'b1; end
               FN_SLT:  begin alu_op = ALU_SLT;  reg_we = 1'b1; end
               FN_SLTU: begin alu_op = ALU_SLTU; reg_we = 1'b1; end
               // Shifts move rt; the amount rides on the ALU B side.
               FN_SLL:  begin alu_op = ALU_SLL; alu_a = rt_val; alu_b = shamt32; reg_we = 1'b1; end
               FN_SRL:  begin alu_op = ALU_SRL; alu_a = rt_val; alu_b = shamt32; reg_we = 1'b1; end
               FN_SRA:  begin alu_op = ALU_SRA; alu_a = rt_val; alu_b = shamt32; reg_we = 1'b1; end
`ifdef MIPS_VAR_SHIFT_EN
               FN_SLLV: begin alu_op = ALU_SLL; alu_a = rt_val; alu_b = {27'd0, rs_val[4:0]}; reg_we = 1'b1; end
               FN_SRLV: begin alu_op = ALU_SRL; alu_a = rt_val; alu_b = {27'd0, rs_val[4:0]}; reg_we = 1'b1; end
               FN_SRAV: begin alu_op = ALU_SRA; alu_a = rt_val; alu_b = {27'd0, rs_val[4:0]}; reg_we = 1'b1; end
`endif
               FN_JR:   pc_next = rs_val;
               default: ;
            endcase
         end
         OP_J:     pc_next = j_target;
         OP_JAL:   begin pc_next = j_target; reg_we = 1'b1; wa = 5'd31; wb_sel = WB_LINK; end
         OP_BEQ:   if (rs_val == rt_val) pc_next = br_target;
         OP_BNE:   if (rs_val != rt_val) pc_next = br_target;
         OP_ADDIU: begin alu_op = ALU_ADD;  alu_b = imm_sext; reg_we = 1'b1; wa = rt_a; end
         OP_SLTI:  begin alu_op = ALU_SLT;  alu_b = imm_sext; reg_we = 1'b1; wa = rt_a; end
         OP_SLTIU: begin alu_op = ALU_SLTU; alu_b = imm_sext; reg_we = 1'b1; wa = rt_a; end
         OP_ANDI:  begin alu_op = ALU_AND;  alu_b = imm_zext; reg_we = 1'b1; wa = rt_a; end
         OP_ORI:   begin alu_op = ALU_OR;   alu_b = imm_zext; reg_we = 1'b1; wa = rt_a; end
         OP_XORI:  begin alu_op = ALU_XOR;  alu_b = imm_zext; reg_we = 1'b1; wa = rt_a; end
         OP_LUI:   begin alu_op = ALU_OR; alu_a = 32'd0; alu_b = {imm16, 16'd0}; reg_we = 1'b1; wa = rt_a; end
         OP_LW:    begin alu_op = ALU_ADD;  alu_b = imm_sext; reg_we = 1'b1; wa = rt_a; wb_sel = WB_MEM; end
         OP_SW:    begin alu_op = ALU_ADD;  alu_b = imm_sext; dm_we = 1'b1; end
         default: ;
      endcase
   end

   assign alu_y = alu_calc(alu_op, alu_a, alu_b);

   // Memory: byte offset bits are dropped, so misaligned addresses just alias.
   assign dm_off = alu_y - DATA_BASE;

   mips_dmem #(.DM_DEPTH(DM_DEPTH)) dm (
      .clk (clk),
      .rst (rst),
      .we  (dm_we),
      .idx (dm_off[DM_AW+1:2]),
      .wd  (rt_val),
      .rd  (dm_rd)
   );

   // Writeback
   always_comb begin
      wd = alu_y;
      case (wb_sel)
         WB_MEM:  wd = dm_rd;
         WB_LINK: wd = pc_plus4;
         default: wd = alu_y;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) PC <= TEXT_BASE;
      else      PC <= pc_next;
   end

   assign unused_bits = &{1'b0, im_off[31:IM_AW+2], im_off[1:0],
                          dm_off[31:DM_AW+2], dm_off[1:0]};

endmodule

// File: tb/tb_mips_core.sv
`timescale 1ns/1ps
module tb_mips_core;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mips_core dut (.clk(clk), .rst(rst));

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          loc;
      logic [31:0] instr;
      logic [4:0]  reg_n;
      logic [31:0] reg_v;
      logic [31:0] pc_v;
      bit          sh_chk;
   } vec_t;

   typedef struct {
      string       name;
      logic [4:0]  reg_n;
      logic [31:0] reg_v;
      logic [31:0] pc_v;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                         input int sh, input int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction

   function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] enc_j(input int op, input int idx);
      return {6'(op), 26'(idx)};
   endfunction

   task automatic add_vec(input int loc, input logic [31:0] instr, input int reg_n,
                          input logic [31:0] reg_v, input logic [31:0] pc_v, input bit sh);
      vec_t v;
      v.loc = loc; v.instr = instr; v.reg_n = 5'(reg_n);
      v.reg_v = reg_v; v.pc_v = pc_v; v.sh_chk = sh;
      vecs.push_back(v);
   endtask

   task automatic clear_im();
      for (int i = 0; i < 1024; i++) dut.im.instruction_memory[i] = 32'd0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t        e;
      logic [31:0] pc_before;
      int          taken;
      int          cyc;
      logic [31:0] sllv_exp;

`ifdef MIPS_VAR_SHIFT_EN
      sllv_exp = 32'h8000_0000;
`else
      sllv_exp = 32'h0000_0000;
`endif

      // ---------------- table: one instruction per record ----------------
      add_vec( 0, enc_i('h0D, 0,  1, 'hFFFF),       1, 32'h0000FFFF, 32'h3004, 0);
      add_vec( 1, enc_i('h09, 0,  2, 'hFFFF),       2, 32'hFFFFFFFF, 32'h3008, 0);
      add_vec( 2, enc_i('h0F, 0,  3, 'h8000),       3, 32'h80000000, 32'h300C, 0);
      add_vec( 3, enc_r(0, 3,  4, 4, 'h00),         4, 32'h00000000, 32'h3010, 1);
      add_vec( 4, enc_r(0, 3,  5, 4, 'h02),         5, 32'h08000000, 32'h3014, 1);
      add_vec( 5, enc_r(0, 3,  6, 4, 'h03),         6, 32'hF8000000, 32'h3018, 1);
      add_vec( 6, enc_i('h09, 0,  0, 5),            0, 32'h00000000, 32'h301C, 0);
      add_vec( 7, enc_i('h09, 0, 10, 1),           10, 32'h00000001, 32'h3020, 0);
      add_vec( 8, enc_r(2, 10, 11, 0, 'h2A),       11, 32'h00000001, 32'h3024, 0);
      add_vec( 9, enc_r(2, 10, 12, 0, 'h2B),       12, 32'h00000000, 32'h3028, 0);
      add_vec(10, enc_r(1, 2, 13, 0, 'h21),        13, 32'h0000FFFE, 32'h302C, 0);
      add_vec(11, enc_r(0, 10, 14, 0, 'h23),       14, 32'hFFFFFFFF, 32'h3030, 0);
      add_vec(12, enc_r(1, 0, 15, 0, 'h27),        15, 32'hFFFF0000, 32'h3034, 0);
      add_vec(13, enc_i('h0E, 1, 16, 'h00F0),      16, 32'h0000FF0F, 32'h3038, 0);
      add_vec(14, enc_i('h0C, 2, 17, 'h1234),      17, 32'h00001234, 32'h303C, 0);
      add_vec(15, enc_i('h0B, 10, 18, 'hFFFF),     18, 32'h00000001, 32'h3040, 0);
      add_vec(16, enc_i('h0A, 10, 19, 'hFFFF),     19, 32'h00000000, 32'h3044, 0);
      add_vec(17, enc_r(3, 10, 20, 0, 'h25),       20, 32'h80000001, 32'h3048, 0);
      add_vec(18, enc_i('h3F, 1, 21, 'h1234),      21, 32'h00000000, 32'h304C, 0);
      add_vec(19, enc_r(1, 10, 22, 0, 'h04),       22, sllv_exp,     32'h3050, 0);
      add_vec(20, enc_i('h04, 0, 0, 1),            23, 32'h00000000, 32'h3058, 0);
      add_vec(22, enc_i('h09, 0, 23, 'h55),        23, 32'h00000055, 32'h305C, 0);
      add_vec(23, enc_r(1, 2, 24, 0, 'h24),        24, 32'h0000FFFF, 32'h3060, 0);
      add_vec(24, enc_r(1, 3, 25, 0, 'h26),        25, 32'h8000FFFF, 32'h3064, 0);

      clear_im();
      foreach (vecs[i]) dut.im.instruction_memory[vecs[i].loc] = vecs[i].instr;
      // Skipped by the taken beq; would clobber $23 if executed.
      dut.im.instruction_memory[21] = enc_i('h09, 0, 23, 'h0BAD);

      do_reset();
      check("reset_pc", dut.PC, 32'h0000_3000);
      for (int n = 0; n < 32; n++) check($sformatf("reset_r%0d", n), dut.rf.rf[n], 32'd0);

      foreach (vecs[i]) begin
         if (vecs[i].sh_chk) check($sformatf("shamt32_%0d", i), dut.shamt32, 32'd4);
         e.name  = $sformatf("vec%0d", i);
         e.reg_n = vecs[i].reg_n;
         e.reg_v = vecs[i].reg_v;
         e.pc_v  = vecs[i].pc_v;
         sb.push_back(e);
         step();
         e = sb.pop_front();
         check({e.name, "_reg"}, dut.rf.rf[e.reg_n], e.reg_v);
         check({e.name, "_pc"},  dut.PC,             e.pc_v);
      end

      // ---------------- loop with memory traffic ----------------
      clear_im();
      dut.im.instruction_memory[0] = enc_i('h09, 0, 25, 5);          // $25 = 5
      dut.im.instruction_memory[1] = enc_i('h09, 0, 8, 0);           // $8 = 0
      dut.im.instruction_memory[2] = enc_j('h02, 'hC04);             // j 0x3010
      dut.im.instruction_memory[3] = enc_i('h09, 8, 8, 1);           // 0x300C: $8++
      dut.im.instruction_memory[4] = enc_i('h05, 8, 25, 'hFFFE);     // 0x3010: bne -> 0x300C
      dut.im.instruction_memory[5] = enc_i('h2B, 0, 8, 'h50);        // sw $8,0x50
      dut.im.instruction_memory[6] = enc_i('h09, 0, 2, 'hFFFF);      // $2 = -1
      dut.im.instruction_memory[7] = enc_i('h2B, 0, 2, 'h54);        // sw $2,0x54
      dut.im.instruction_memory[8] = enc_i('h23, 0, 9, 'h54);        // lw $9,0x54
      dut.im.instruction_memory[9] = enc_i('h23, 0, 10, 'h57);       // misaligned lw
      do_reset();
      taken = 0;
      cyc   = 0;
      while (dut.PC != 32'h3028 && cyc < 60) begin
         pc_before = dut.PC;
         step();
         cyc++;
         if (pc_before == 32'h3010 && dut.PC == 32'h300C) taken++;
      end
      check("loop_end_pc",  dut.PC, 32'h3028);
      check("loop_taken",   32'(taken), 32'd5);
      check("loop_r8",      dut.rf.rf[8], 32'd5);
      check("loop_dm20",    dut.dm.dataMem[20], 32'd5);
      check("loop_r9",      dut.rf.rf[9], 32'hFFFFFFFF);
      check("misalign_r10", dut.rf.rf[10], 32'hFFFFFFFF);

      // ---------------- jal / jr / j ----------------
      clear_im();
      dut.im.instruction_memory[0] = enc_j('h03, 'hC04);             // jal 0x3010
      dut.im.instruction_memory[1] = enc_i('h09, 0, 5, 'h77);        // 0x3004
      dut.im.instruction_memory[2] = enc_j('h02, 'hC02);             // 0x3008: j self
      dut.im.instruction_memory[3] = enc_i('h09, 0, 6, 'h99);        // never reached
      dut.im.instruction_memory[4] = enc_i('h09, 0, 7, 'h33);        // 0x3010
      dut.im.instruction_memory[5] = enc_r(31, 0, 0, 0, 'h08);       // jr $31
      do_reset();
      step();
      check("jal_r31", dut.rf.rf[31], 32'h3004);
      check("jal_pc",  dut.PC, 32'h3010);
      step();
      check("ctl_r7",  dut.rf.rf[7], 32'h33);
      step();
      check("jr_pc",   dut.PC, 32'h3004);
      step();
      check("ctl_r5",  dut.rf.rf[5], 32'h77);
      step();
      step();
      check("j_self_pc", dut.PC, 32'h3008);
      check("ctl_r6",    dut.rf.rf[6], 32'h0);

      // ---------------- reset with a store in flight ----------------
      clear_im();
      dut.im.instruction_memory[0] = enc_i('h09, 0, 1, 'h1234);
      dut.im.instruction_memory[1] = enc_i('h09, 0, 2, 'h40);
      dut.im.instruction_memory[2] = enc_i('h2B, 2, 1, 0);           // dm[16] = 0x1234
      dut.im.instruction_memory[3] = enc_i('h09, 0, 4, 'h5678);
      for (int i = 4; i < 19; i++) dut.im.instruction_memory[i] = enc_i('h09, 3, 3, 1);
      dut.im.instruction_memory[19] = enc_i('h2B, 2, 4, 0);          // sw $4 -> dm[16]
      do_reset();
      repeat (19) step();
      check("mid_pc_before", dut.PC, 32'h304C);
      check("mid_r3",        dut.rf.rf[3], 32'd15);
      check("mid_dm16_pre",  dut.dm.dataMem[16], 32'h1234);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_pc_reset", dut.PC, 32'h3000);
      for (int n = 1; n < 5; n++) check($sformatf("mid_r%0d", n), dut.rf.rf[n], 32'd0);
      step();
      check("mid_dm16_kept", dut.dm.dataMem[16], 32'h1234);
      check("mid_pc_held",   dut.PC, 32'h3000);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_pc_release", dut.PC, 32'h3000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
